// File: rtl/tmr_counter_scrub.sv
// Triple-redundant counter with majority vote, fault injection, delayed scrub
// and sticky fatal detection for downstream status logic.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | replicas agree, watching for a mismatch
// ST_HOLD  | mismatch seen, waiting SCRUB_DELAY cycles for a self-clear
// ST_SCRUB | forcing all replicas to the voted value (one cycle)
module tmr_counter_scrub #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RST_VAL     = '0,
    parameter int              SCRUB_DELAY = 4,
    parameter int              CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             inj_en,
    input  logic [1:0]       inj_sel,
    input  logic [WIDTH-1:0] inj_mask,
    output logic [WIDTH-1:0] voted_count,
    output logic             err_flag,
    output logic [2:0]       err_lane,
    output logic             scrub_pulse,
    output logic [CNT_W-1:0] corr_count,
    output logic             fatal
);

    localparam int TMR_W = (SCRUB_DELAY < 2) ? 1 : $clog2(SCRUB_DELAY + 1);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'((SCRUB_DELAY > 0) ? SCRUB_DELAY - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SCRUB = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [2:0]       lane_nxt;
    logic [CNT_W-1:0] corr_nxt;
    logic [WIDTH-1:0] rep     [3];
    logic [WIDTH-1:0] rep_nxt [3];
    logic [WIDTH-1:0] inc;
    logic [2:0]       mis;
    logic             fat;

    assign inc         = {{(WIDTH-1){1'b0}}, en};
    assign voted_count = (rep[0] & rep[1]) | (rep[1] & rep[2]) | (rep[0] & rep[2]);
    assign mis         = {rep[2] != voted_count, rep[1] != voted_count, rep[0] != voted_count};
    assign fat         = (rep[0] != rep[1]) && (rep[1] != rep[2]) && (rep[0] != rep[2]);
    assign err_flag    = (state != ST_IDLE);
    assign scrub_pulse = (state == ST_SCRUB);

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        lane_nxt  = err_lane;
        corr_nxt  = corr_count;
        for (int i = 0; i < 3; i++) begin
            rep_nxt[i] = (rep[i] + inc) ^ ((inj_en && inj_sel == 2'(i)) ? inj_mask : '0);
        end

        case (state)
            ST_IDLE: begin
                if (|mis) begin
                    lane_nxt = mis;
                    if (SCRUB_DELAY == 0) begin
                        state_nxt = ST_SCRUB;
                    end else begin
                        state_nxt = ST_HOLD;
                        tmr_nxt   = HOLD_LOAD;
                    end
                end
            end
            ST_HOLD: begin
                if (!(|mis)) begin
                    state_nxt = ST_IDLE;
                    lane_nxt  = '0;
                end else begin
                    lane_nxt = err_lane | mis;
                    if (tmr == '0) begin
                        state_nxt = ST_SCRUB;
                    end else begin
                        tmr_nxt = tmr - TMR_W'(1);
                    end
                end
            end
            ST_SCRUB: begin
                // injection is deliberately dropped while resyncing
                for (int i = 0; i < 3; i++) begin
                    rep_nxt[i] = voted_count + inc;
                end
                if (corr_count != {CNT_W{1'b1}}) begin
                    corr_nxt = corr_count + CNT_W'(1);
                end
                lane_nxt  = '0;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
                lane_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            err_lane   <= '0;
            corr_count <= '0;
            fatal      <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                rep[i] <= RST_VAL;
            end
        end else begin
            state      <= state_nxt;
            tmr        <= tmr_nxt;
            err_lane   <= lane_nxt;
            corr_count <= corr_nxt;
            fatal      <= fatal | fat;
            for (int i = 0; i < 3; i++) begin
                rep[i] <= rep_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_tmr_counter_scrub.sv
// Bench for tmr_counter_scrub: two configurations on shared stimulus, directed
// table plus corner sequences, and random traffic against a reference model.
module tb_tmr_counter_scrub;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b0;
    logic         en       = 1'b0;
    logic         inj_en   = 1'b0;
    logic [1:0]   inj_sel  = 2'd3;
    logic [W-1:0] inj_mask = '0;

    logic [W-1:0] voted_a, voted_b;
    logic         err_a, err_b, scrub_a, scrub_b, fatal_a, fatal_b;
    logic [2:0]   lane_a, lane_b;
    logic [7:0]   corr_a;
    logic [1:0]   corr_b;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    int scrub_seen = 0;

    always #5 clk = ~clk;

    tmr_counter_scrub #(.WIDTH(W), .RST_VAL(8'h00), .SCRUB_DELAY(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .inj_en(inj_en), .inj_sel(inj_sel),
        .inj_mask(inj_mask), .voted_count(voted_a), .err_flag(err_a), .err_lane(lane_a),
        .scrub_pulse(scrub_a), .corr_count(corr_a), .fatal(fatal_a)
    );

    tmr_counter_scrub #(.WIDTH(W), .RST_VAL(8'h00), .SCRUB_DELAY(0), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .inj_en(inj_en), .inj_sel(inj_sel),
        .inj_mask(inj_mask), .voted_count(voted_b), .err_flag(err_b), .err_lane(lane_b),
        .scrub_pulse(scrub_b), .corr_count(corr_b), .fatal(fatal_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: index 0 = (delay 4, 8-bit corr), index 1 = (delay 0, 2-bit corr).
    // m_hold < 0 means no pending fault; otherwise it is the number of HOLD cycles already spent.
    int unsigned m_r [2][3];
    int          m_hold [2];
    bit          m_scrub [2];
    int unsigned m_lane [2];
    int unsigned m_corr [2];
    bit          m_fatal [2];

    function automatic int unsigned maj3(input int unsigned a, input int unsigned b, input int unsigned c);
        return (a & b) | (b & c) | (a & c);
    endfunction

    function automatic int unsigned m_vote(input int d);
        return maj3(m_r[d][0], m_r[d][1], m_r[d][2]);
    endfunction

    task automatic model_step(input int d);
        int unsigned v, mis, inc;
        int dly, cmax;
        dly  = (d == 0) ? 4 : 0;
        cmax = (d == 0) ? 255 : 3;
        inc  = en ? 1 : 0;
        v    = m_vote(d);
        mis  = 0;
        for (int i = 0; i < 3; i++) if (m_r[d][i] != v) mis |= (1 << i);
        if (m_r[d][0] != m_r[d][1] && m_r[d][1] != m_r[d][2] && m_r[d][0] != m_r[d][2])
            m_fatal[d] = 1'b1;
        if (m_scrub[d]) begin
            for (int i = 0; i < 3; i++) m_r[d][i] = (v + inc) % 256;
            if (m_corr[d] < cmax) m_corr[d]++;
            m_lane[d]  = 0;
            m_scrub[d] = 1'b0;
            m_hold[d]  = -1;
        end else begin
            for (int i = 0; i < 3; i++)
                m_r[d][i] = ((m_r[d][i] + inc) % 256) ^ ((inj_en && inj_sel == 2'(i)) ? int'(inj_mask) : 0);
            if (m_hold[d] < 0) begin
                if (mis != 0) begin
                    m_lane[d] = mis;
                    if (dly == 0) m_scrub[d] = 1'b1;
                    else          m_hold[d]  = 0;
                end
            end else if (mis == 0) begin
                m_hold[d] = -1;
                m_lane[d] = 0;
            end else begin
                m_lane[d] |= mis;
                if (m_hold[d] == dly - 1) begin
                    m_scrub[d] = 1'b1;
                    m_hold[d]  = -1;
                end else begin
                    m_hold[d]++;
                end
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 3; i++) m_r[d][i] = 0;
                m_hold[d] = -1; m_scrub[d] = 1'b0; m_lane[d] = 0; m_corr[d] = 0; m_fatal[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    always @(negedge clk) begin
        if (chk_on && rst_n) begin
            chk("m_voted_a", 32'(voted_a), m_vote(0));
            chk("m_err_a",   32'(err_a),   32'((m_hold[0] >= 0) || m_scrub[0]));
            chk("m_lane_a",  32'(lane_a),  m_lane[0]);
            chk("m_scrub_a", 32'(scrub_a), 32'(m_scrub[0]));
            chk("m_corr_a",  32'(corr_a),  m_corr[0]);
            chk("m_fatal_a", 32'(fatal_a), 32'(m_fatal[0]));
            for (int i = 0; i < 3; i++) chk("m_rep_a", 32'(dut.rep[i]), m_r[0][i]);
            chk("m_voted_b", 32'(voted_b), m_vote(1));
            chk("m_err_b",   32'(err_b),   32'((m_hold[1] >= 0) || m_scrub[1]));
            chk("m_lane_b",  32'(lane_b),  m_lane[1]);
            chk("m_scrub_b", 32'(scrub_b), 32'(m_scrub[1]));
            chk("m_corr_b",  32'(corr_b),  m_corr[1]);
            chk("m_fatal_b", 32'(fatal_b), 32'(m_fatal[1]));
        end
        if (scrub_a) scrub_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic ie, input logic [1:0] s, input logic [7:0] m);
        en = e; inj_en = ie; inj_sel = s; inj_mask = m;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       ie;
        logic [1:0] sel;
        logic [7:0] mask;
        logic [7:0] voted;
        logic       err;
        logic [2:0] lane;
        logic       scrub;
        logic [7:0] corr;
    } vec_t;

    vec_t tbl [8];

    initial begin
        // starting from voted=10, en=1: single-lane hit on replica 1 at t0
        tbl[0] = '{1'b1, 1'b1, 2'd1, 8'h80, 8'd11, 1'b0, 3'b000, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd12, 1'b1, 3'b010, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd13, 1'b1, 3'b010, 1'b0, 8'd0};
        tbl[3] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd14, 1'b1, 3'b010, 1'b0, 8'd0};
        tbl[4] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd15, 1'b1, 3'b010, 1'b0, 8'd0};
        tbl[5] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd16, 1'b1, 3'b010, 1'b1, 8'd0};
        tbl[6] = '{1'b1, 1'b0, 2'd3, 8'h00, 8'd17, 1'b0, 3'b000, 1'b0, 8'd1};
        tbl[7] = '{1'b0, 1'b0, 2'd3, 8'h00, 8'd17, 1'b0, 3'b000, 1'b0, 8'd1};

        #1;
        chk("rst_voted", 32'(voted_a), 0);
        chk("rst_err",   32'(err_a),   0);
        chk("rst_scrub", 32'(scrub_a), 0);
        chk("rst_corr",  32'(corr_a),  0);
        chk("rst_fatal", 32'(fatal_a), 0);
        do_reset();
        chk_on = 1'b1;

        drive(1'b1, 1'b0, 2'd3, 8'h00);
        repeat (10) step();
        chk("count10_voted", 32'(voted_a), 10);
        chk("count10_err",   32'(err_a),   0);
        chk("count10_corr",  32'(corr_a),  0);

        for (int k = 0; k < 8; k++) begin
            drive(tbl[k].en, tbl[k].ie, tbl[k].sel, tbl[k].mask);
            step();
            chk("tbl_voted", 32'(voted_a), 32'(tbl[k].voted));
            chk("tbl_err",   32'(err_a),   32'(tbl[k].err));
            chk("tbl_lane",  32'(lane_a),  32'(tbl[k].lane));
            chk("tbl_scrub", 32'(scrub_a), 32'(tbl[k].scrub));
            chk("tbl_corr",  32'(corr_a),  32'(tbl[k].corr));
            if (k == 0) chk("tbl_r1_hit", 32'(dut.rep[1]), 32'h8B);
            if (k == 6) begin
                chk("tbl_r0_sync", 32'(dut.rep[0]), 17);
                chk("tbl_r1_sync", 32'(dut.rep[1]), 17);
                chk("tbl_r2_sync", 32'(dut.rep[2]), 17);
            end
        end

        drive(1'b1, 1'b0, 2'd3, 8'h00);
        repeat (238) step();
        chk("wrap_255", 32'(voted_a), 255);
        step();
        chk("wrap_0",     32'(voted_a), 0);
        chk("wrap_noerr", 32'(err_a),   0);

        // transient fault that cancels itself before the scrub delay expires
        do_reset();
        drive(1'b1, 1'b0, 2'd3, 8'h00);
        repeat (16) step();
        scrub_seen = 0;
        drive(1'b0, 1'b1, 2'd2, 8'h01);
        step();
        chk("self_r2_hit", 32'(dut.rep[2]), 32'h11);
        step();
        chk("self_r2_back", 32'(dut.rep[2]), 32'h10);
        chk("self_err_hold", 32'(err_a), 1);
        drive(1'b0, 1'b0, 2'd3, 8'h00);
        repeat (6) step();
        chk("self_err",      32'(err_a),    0);
        chk("self_noscrub",  32'(scrub_seen), 0);
        chk("self_corr",     32'(corr_a),   0);

        // two replicas hit on consecutive cycles: all three disagree
        drive(1'b0, 1'b1, 2'd0, 8'h01);
        step();
        drive(1'b0, 1'b1, 2'd1, 8'h02);
        step();
        drive(1'b0, 1'b0, 2'd3, 8'h00);
        chk("fat_r0", 32'(dut.rep[0]), 32'h11);
        chk("fat_r1", 32'(dut.rep[1]), 32'h12);
        chk("fat_r2", 32'(dut.rep[2]), 32'h10);
        chk("fat_voted", 32'(voted_a), 32'h10);
        step();
        chk("fat_set", 32'(fatal_a), 1);
        repeat (6) step();
        for (int i = 0; i < 3; i++) chk("fat_scrubbed", 32'(dut.rep[i]), 32'h10);
        chk("fat_sticky", 32'(fatal_a), 1);
        chk("fat_corr",   32'(corr_a),  1);
        chk("fat_err",    32'(err_a),   0);

        // correction counter saturation (2-bit counter in dut2)
        do_reset();
        drive(1'b0, 1'b0, 2'd3, 8'h00);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b1, 2'(k % 3), 8'(1 << k));
            step();
            drive(1'b0, 1'b0, 2'd3, 8'h00);
            repeat (8) step();
            chk("sat_corr_a", 32'(corr_a), 32'(k + 1));
            chk("sat_corr_b", 32'(corr_b), 32'((k < 3) ? k + 1 : 3));
        end

        // asynchronous reset in the middle of HOLD
        drive(1'b0, 1'b1, 2'd0, 8'h01);
        step();
        drive(1'b0, 1'b1, 2'd1, 8'h02);
        step();
        drive(1'b0, 1'b0, 2'd3, 8'h00);
        step();
        chk("mid_pre_fatal", 32'(fatal_a), 1);
        chk("mid_pre_err",   32'(err_a),   1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_voted", 32'(voted_a), 0);
        chk("mid_err",   32'(err_a),   0);
        chk("mid_lane",  32'(lane_a),  0);
        chk("mid_fatal", 32'(fatal_a), 0);
        chk("mid_corr",  32'(corr_a),  0);
        chk("mid_scrub", 32'(scrub_a), 0);
        step();
        step();
        rst_n = 1'b1;
        scrub_seen = 0;
        repeat (8) step();
        chk("mid_noscrub", 32'(scrub_seen), 0);
        chk("mid_err_after", 32'(err_a), 0);

        // random traffic, checked every cycle by the model
        for (int n = 0; n < 3000; n++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
                  2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            step();
        end

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
